// File: rtl/ascii_pkg.sv
// Shared ASCII console definitions: character constants, parser state
// encoding and error codes used by the receive parser and transmit formatter.
package ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } parse_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational ASCII classifier: decimal digit, token delimiter, digit value.
module ascii_char_class
  import ascii_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_digit,
  output logic       is_delim,
  output logic [3:0] digit
);

  // Classify the byte; digit value is only meaningful when is_digit is set
  always_comb begin
    is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    is_delim = (rx_data == ASCII_CR) || (rx_data == ASCII_LF) ||
               (rx_data == ASCII_SP) || (rx_data == ASCII_COMMA);
    digit    = rx_data[3:0];
  end

endmodule

// File: rtl/ascii_dec_parser.sv
// Decimal ASCII token parser: rebuilds an 8-bit unsigned value from a
// delimiter-terminated digit string, flagging illegal characters, overflow
// and inter-character timeouts.
module ascii_dec_parser
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] value_out,
  output logic       value_valid,
  output logic       parse_err,
  output logic [1:0] err_code
);

  localparam int unsigned NDW = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
  // Counter only ever holds 0..TIMEOUT_CYCLES-1; the terminal edge fires instead
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NDW-1:0] NDIG_MAX = NDW'(MAX_DIGITS);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  parse_state_t   state;
  logic [7:0]     acc;
  logic [NDW-1:0] ndig;
  logic [TCW-1:0] tmo_cnt;

  logic           is_digit;
  logic           is_delim;
  logic [3:0]     digit;
  logic [11:0]    next_acc;

  ascii_char_class u_char_class (
    .rx_data  (rx_data),
    .is_digit (is_digit),
    .is_delim (is_delim),
    .digit    (digit)
  );

  // Candidate accumulator at 12 bits so values above 255 are detectable
  always_comb begin
    next_acc = ({4'b0, acc} * 12'd10) + {8'b0, digit};
  end

  // Token state machine with accumulator, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ndig        <= '0;
      tmo_cnt     <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done) begin
            if (is_digit) begin
              acc     <= {4'b0, digit};
              ndig    <= NDW'(1);
              tmo_cnt <= '0;
              state   <= ACCUM;
            end else if (!is_delim) begin
              parse_err <= 1'b1;
              err_code  <= ERR_CHAR;
              state     <= DISCARD;
            end
          end
        end
        ACCUM: begin
          if (rx_done) begin
            // A byte on the terminal timeout edge wins over the timeout
            tmo_cnt <= '0;
            if (is_digit) begin
              if ((ndig == NDIG_MAX) || (next_acc > 12'd255)) begin
                parse_err <= 1'b1;
                err_code  <= ERR_OVF;
                state     <= DISCARD;
              end else begin
                acc  <= next_acc[7:0];
                ndig <= ndig + NDW'(1);
              end
            end else if (is_delim) begin
              value_out   <= acc;
              value_valid <= 1'b1;
              state       <= IDLE;
            end else begin
              parse_err <= 1'b1;
              err_code  <= ERR_CHAR;
              state     <= DISCARD;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            if (tmo_cnt == TMO_LAST) begin
              parse_err <= 1'b1;
              err_code  <= ERR_TMO;
              tmo_cnt   <= '0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TCW'(1);
            end
          end
        end
        DISCARD: begin
          if (rx_done && is_delim) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Self-checking bench for ascii_dec_parser with a token-level reference model.
module tb_ascii_dec_parser;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] value_out;
  logic       value_valid;
  logic       parse_err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  // Reference model: text-level view of the current token
  int  m_val = 0, m_vv = 0, m_pe = 0, m_ec = 0;
  bit  m_in_num = 0, m_skip = 0;
  int  m_digits[$];
  int  m_gap = 0;

  always #5 clk = ~clk;

  ascii_dec_parser #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .value_out   (value_out),
    .value_valid (value_valid),
    .parse_err   (parse_err),
    .err_code    (err_code)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_val = 0; m_vv = 0; m_pe = 0; m_ec = 0;
    m_in_num = 0; m_skip = 0; m_gap = 0;
    m_digits.delete();
  endfunction

  function automatic void model_err(input int code);
    m_pe = 1; m_ec = code; m_in_num = 0; m_skip = 1;
    m_digits.delete();
  endfunction

  function automatic void model_step(input bit rd, input logic [7:0] d);
    bit is_dig, is_del;
    m_vv = 0; m_pe = 0;
    is_dig = (d >= 8'h30) && (d <= 8'h39);
    is_del = (d == 8'h0D) || (d == 8'h0A) || (d == 8'h20) || (d == 8'h2C);
    if (rd) begin
      m_gap = 0;
      if (m_skip) begin
        if (is_del) m_skip = 0;
      end else if (is_dig) begin
        m_digits.push_back(int'(d) - 48);
        m_in_num = 1;
        if (m_digits.size() > 3 || digits_value() > 255) model_err(2);
      end else if (is_del) begin
        if (m_in_num) begin
          m_val = digits_value(); m_vv = 1;
        end
        m_in_num = 0;
        m_digits.delete();
      end else begin
        model_err(1);
      end
    end else if (m_in_num) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_pe = 1; m_ec = 3; m_in_num = 0;
        m_digits.delete();
      end
    end
  endfunction

  task automatic compare_all();
    check("value_valid", int'(value_valid), m_vv);
    check("parse_err",   int'(parse_err),   m_pe);
    check("value_out",   int'(value_out),   m_val);
    check("err_code",    int'(err_code),    m_ec);
    if (value_valid && parse_err) check("exclusive_pulses", 1, 0);
  endtask

  task automatic cyc(input bit rd, input logic [7:0] d);
    @(negedge clk);
    rx_done = rd;
    rx_data = rd ? d : 8'h00;
    model_step(rd, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_char();
    int unsigned r = $urandom_range(99);
    logic [7:0] dl[4] = '{8'h0D, 8'h0A, 8'h20, 8'h2C};
    if (r < 60) return 8'(8'h30 + $urandom_range(9));
    if (r < 85) return dl[$urandom_range(3)];
    return 8'(8'h3A + $urandom_range(60));
  endfunction

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    send_str("123\r");
    check("tok_123", int'(value_out), 123);

    send_str("255\n");
    check("tok_255", int'(value_out), 255);
    send_str("256");
    check("ovf_256_code", int'(err_code), 2);
    send_str("\n");
    check("ovf_256_hold", int'(value_out), 255);

    send_str("0007 ");
    check("lead0_code", int'(err_code), 2);
    send_str("9 ");
    check("recover_9", int'(value_out), 9);

    send_str("4x");
    check("illegal_code", int'(err_code), 1);
    send_str("2\r\r,8\r");
    check("after_illegal", int'(value_out), 8);

    // Silence after a digit: pulse lands 17 cycles after the strobe
    send_str("5");
    idle(TMO);
    check("timeout_code", int'(err_code), 3);
    send_str("6\r");
    check("after_timeout", int'(value_out), 6);

    // Byte on the terminal timeout edge is accepted
    send_str("5");
    idle(TMO - 1);
    send_str("3\r");
    check("edge_byte", int'(value_out), 53);
    check("edge_no_tmo", int'(err_code), 3);

    send_str("007\r");
    check("tok_007", int'(value_out), 7);

    send_str("99\r");
    check("b2b_99", int'(value_out), 99);
    send_str("12");
    apply_reset();
    idle(4);
    check("post_reset_val", int'(value_out), 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 3) idle(TMO - 2 + $urandom_range(4));
      else if ($urandom_range(99) < 60) cyc(1'b1, rand_char());
      else cyc(1'b0, 8'h00);
      if (n == 1500) apply_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Receive-side decimal parser for the UART console path: takes received ASCII bytes one at a time and rebuilds an unsigned 8-bit value from a decimal digit string such as "0"–"255". It produces one result per delimiter-terminated token. It is the inverse of the byte-to-three-decimal-ASCII formatter on the transmit path. It sits between the UART receiver and the command/register logic, and flags malformed, overflowing or stalled tokens.

## Interface
- MAX_DIGITS, 3: maximum digits accepted per token, leading zeros included.
- TIMEOUT_CYCLES, 0: idle clk cycles allowed between characters inside a token; 0 disables the timeout.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_data  input  8  received ASCII byte; valid only when rx_done=1.
- rx_done  input  1  one-cycle strobe per received byte; strobes in back-to-back cycles are distinct bytes.
- value_out  output  8  last successfully parsed value; holds until the next success.
- value_valid  output  1  one-cycle pulse when value_out is updated.
- parse_err  output  1  one-cycle pulse on any token error.
- err_code  output  2  cause of the last error: 1 illegal character, 2 overflow or too many digits, 3 timeout; holds until the next error.

## Operation
- Character classes:
  - Digit: 0x30–0x39.
  - Delimiter: 0x0D CR, 0x0A LF, 0x20 space, 0x2C comma.
  - Illegal: everything else.
- Registers: acc (8 bits), ndig (0..MAX_DIGITS), state ∈ {IDLE, ACCUM, DISCARD}, and a timeout counter.
- IDLE, on rx_done:
  - Digit: acc = digit value, ndig = 1, go to ACCUM.
  - Delimiter: ignored; empty tokens and repeated delimiters produce nothing.
  - Illegal: parse_err, err_code = 1, go to DISCARD.
- ACCUM, on rx_done:
  - Digit: compute next = acc*10 + d at 12-bit width.
    - If ndig == MAX_DIGITS or next > 255: parse_err, err_code = 2, go to DISCARD.
    - Otherwise acc = next[7:0], ndig++.
  - Delimiter: value_out = acc, value_valid, go to IDLE.
  - Illegal: parse_err, err_code = 1, go to DISCARD.
- DISCARD: ignore all bytes until a delimiter, then go to IDLE. No output and no further errors for the same token.
- Timeout (TIMEOUT_CYCLES > 0, ACCUM only):
  - The counter clears on entry to ACCUM and on every rx_done.
  - It increments on every other cycle.
  - On reaching TIMEOUT_CYCLES: parse_err, err_code = 3, acc is dropped, go to IDLE (not DISCARD).
- Leading zeros count toward MAX_DIGITS:
  - "007" → 7.
  - "0007" → error 2.
- acc and ndig are don't-care outside ACCUM. value_out is never changed by an error.

## Timing
- Reset values: value_out = 0, value_valid = 0, parse_err = 0, err_code = 0, state IDLE, acc = 0, ndig = 0, counter = 0.
- Reset mid-token: the partial token is discarded, with no pulse.
- Latency: value_valid and parse_err are registered and assert in the cycle after the clk edge that samples the rx_done which completes or breaks the token. value_out and err_code are valid in that same cycle.
- value_valid and parse_err are never high in the same cycle.
- Throughput: one byte per cycle, with no back-pressure. The block has no ready signal and drops nothing.
- Timeout and rx_done on the same edge: rx_done wins; the byte is processed and the counter clears.
- The timeout fires exactly TIMEOUT_CYCLES cycles after the last in-token rx_done; the pulse follows on the next cycle.

## Structure
- Shared package ascii_pkg holds:
  - Character constants: ASCII_0, ASCII_9, ASCII_CR, ASCII_LF, ASCII_SP, ASCII_COMMA.
  - State enum parse_state_t.
  - Error code constants ERR_NONE, ERR_CHAR, ERR_OVF, ERR_TMO.
- The formatter on the transmit path reuses ASCII_0 from the same package.
- One natural sub-module: ascii_char_class. It is combinational, maps rx_data to {is_digit, is_delim, digit[3:0]}, and is reusable by other console parsers.
- The state machine, accumulator and timeout counter stay in ascii_dec_parser.

## Test plan
- "1","2","3",CR → value_valid once, value_out = 123; no parse_err.
- "2","5","5",LF then "2","5","6",LF → first token gives 255. Second gives parse_err with err_code = 2 at the "6"; "256" never reaches value_out, which stays 255.
- "0","0","0","7",SP → err_code = 2 on the fourth digit. Then "9",SP → 9, showing DISCARD recovery at the delimiter.
- "4","x","2",CR,CR,",","8",CR → err_code = 1 at "x". The first CR ends DISCARD; the following CR and comma produce nothing; then value_out = 8.
- TIMEOUT_CYCLES = 16: "5" then silence → parse_err with err_code = 3, 17 cycles after the "5" strobe. Then "6",CR → 6. A byte arriving exactly on the timeout edge is processed with no error.
- Back-to-back rx_done strobes "9","9",CR on consecutive cycles → value_out = 99. Assert rst_n low in the middle of a second token "1","2" → all outputs 0 and no pulses after release.
